// File: rtl/and_gate_n_qualified.sv
// -----------------------------------------------------------------------------
// and_gate_n_qualified
//
// Purpose
//   N-input AND gate with a per-input inversion (bubble) mask. The gate drives
//   a combinational raw output for legacy paths. It also drives a registered,
//   glitch-qualified level and one-cycle rise/fall strobes for control FSMs.
//   Typical terms combined here are bus-ready, interrupt-enable and DMA-grant
//   lines, which may come from other clock domains or be asynchronous.
//
// Parameters
//   NR_INPUTS      number of gate inputs, 1..64
//   BubblesMask    bit i = 1 inverts inputs[i] before the AND; bits at or
//                  above NR_INPUTS are ignored
//   FILTER_CYCLES  number of consecutive samples that must disagree with
//                  result before result follows them, >= 1
//
// Ports
//   sysclk      in   system clock; all state changes on its rising edge
//   sys_rst     in   asynchronous active-high reset
//   enable      in   1 = qualify and update; 0 = hold result, discard progress
//   inputs      in   [NR_INPUTS-1:0] gate inputs; may be asynchronous
//   raw_result  out  combinational AND of the mask-corrected inputs
//   result      out  registered, qualified AND result
//   rise_pulse  out  one-cycle strobe when result goes 0->1
//   fall_pulse  out  one-cycle strobe when result goes 1->0
// -----------------------------------------------------------------------------
module and_gate_n_qualified #(
  parameter int unsigned  NR_INPUTS     = 4,
  parameter logic [63:0]  BubblesMask   = 64'h0,
  parameter int unsigned  FILTER_CYCLES = 2
) (
  input  logic                 sysclk,
  input  logic                 sys_rst,
  input  logic                 enable,
  input  logic [NR_INPUTS-1:0] inputs,
  output logic                 raw_result,
  output logic                 result,
  output logic                 rise_pulse,
  output logic                 fall_pulse
);

  // The counter is one bit wider than strictly needed. This keeps the width
  // nonzero when FILTER_CYCLES = 1.
  localparam int unsigned           CNT_W    = $clog2(FILTER_CYCLES) + 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [NR_INPUTS-1:0]  MASK     = BubblesMask[NR_INPUTS-1:0];

  logic [NR_INPUTS-1:0] w_s_real;
  logic                 w_raw;

  logic                 r_raw_q;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_result;
  logic                 r_rise;
  logic                 r_fall;

  // Mask correction and the raw AND are pure combinational logic. Reset and
  // enable have no effect on them.
  assign w_s_real = inputs ^ MASK;
  assign w_raw    = &w_s_real;

  // The raw AND is sampled on every edge, whatever the value of enable.
  // Qualification works on this sample, so an input change needs one edge to
  // reach r_raw_q. It then needs FILTER_CYCLES more edges before result
  // follows it.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_raw_q <= 1'b0;
    end else begin
      r_raw_q <= w_raw;
    end
  end

  // Qualification counter. The priority order is:
  //   disabled -> sample agrees with result -> count at terminal -> count up
  // When the sample goes back to the current result, progress is lost. So a
  // flip shorter than FILTER_CYCLES samples never reaches result.
  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt    <= '0;
      r_result <= 1'b0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else if (!enable) begin
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (r_raw_q == r_result) begin
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_result <= r_raw_q;
      r_cnt    <= '0;
      r_rise   <= r_raw_q;
      r_fall   <= ~r_raw_q;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign raw_result = w_raw;
  assign result     = r_result;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule

// File: tb/tb_and_gate_n_qualified.sv
module tb_and_gate_n_qualified;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] in_a, in_b, in_c;
  logic       raw_a, res_a, rise_a, fall_a;
  logic       raw_b, res_b, rise_b, fall_b;
  logic       raw_c, res_c, rise_c, fall_c;

  int n_checks = 0;
  int n_errors = 0;

  logic prev_rise_a = 1'b0, prev_fall_a = 1'b0;
  logic prev_rise_b = 1'b0, prev_fall_b = 1'b0;

  // Instance A: no mask, FILTER_CYCLES = 3
  and_gate_n_qualified #(.NR_INPUTS(4), .BubblesMask(64'h0), .FILTER_CYCLES(3)) u_dut_a (
    .sysclk(clk), .sys_rst(rst), .enable(en), .inputs(in_a),
    .raw_result(raw_a), .result(res_a), .rise_pulse(rise_a), .fall_pulse(fall_a));

  // Instance B: input 0 inverted, FILTER_CYCLES = 3
  and_gate_n_qualified #(.NR_INPUTS(4), .BubblesMask(64'h1), .FILTER_CYCLES(3)) u_dut_b (
    .sysclk(clk), .sys_rst(rst), .enable(en), .inputs(in_b),
    .raw_result(raw_b), .result(res_b), .rise_pulse(rise_b), .fall_pulse(fall_b));

  // Instance C: no mask, FILTER_CYCLES = 1
  and_gate_n_qualified #(.NR_INPUTS(4), .BubblesMask(64'h0), .FILTER_CYCLES(1)) u_dut_c (
    .sysclk(clk), .sys_rst(rst), .enable(en), .inputs(in_c),
    .raw_result(raw_c), .result(res_c), .rise_pulse(rise_c), .fall_pulse(fall_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_a = 4'b0000; in_b = 4'b0000; in_c = 4'b0000;
    en   = 1'b1;
    rst  = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
  endtask

  // The FILTER_CYCLES = 3 instances must never drive both pulses at once.
  // They must also never hold a pulse on two consecutive cycles.
  always @(negedge clk) begin
    chk("excl_a", {31'd0, rise_a & fall_a}, 32'd0);
    chk("excl_b", {31'd0, rise_b & fall_b}, 32'd0);
    chk("excl_c", {31'd0, rise_c & fall_c}, 32'd0);
    chk("consec_a", {31'd0, (rise_a & prev_rise_a) | (fall_a & prev_fall_a)}, 32'd0);
    chk("consec_b", {31'd0, (rise_b & prev_rise_b) | (fall_b & prev_fall_b)}, 32'd0);
    prev_rise_a = rise_a; prev_fall_a = fall_a;
    prev_rise_b = rise_b; prev_fall_b = fall_b;
  end

  // Expected result/rise/fall for instance C after edges 1..8. The inputs
  // change before edges 1, 3, 5 and 7.
  logic [2:0] t6_exp [1:8] = '{3'b000, 3'b110, 3'b100, 3'b001,
                               3'b000, 3'b110, 3'b100, 3'b001};

  initial begin
    rst = 1'b1; en = 1'b1;
    in_a = 4'b0000; in_b = 4'b0000; in_c = 4'b0000;

    // Reset state
    do_reset();
    chk("rst_res", {31'd0, res_a}, 32'd0);
    chk("rst_rise", {31'd0, rise_a}, 32'd0);
    chk("rst_fall", {31'd0, fall_a}, 32'd0);
    chk("rst_raw", {31'd0, raw_a}, 32'd0);

    // T1: 0000 -> 1111, result rises after edge 3
    in_a = 4'b1111;
    #1;
    chk("t1_raw", {31'd0, raw_a}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_res_early", {31'd0, res_a}, 32'd0);
      chk("t1_rise_early", {31'd0, rise_a}, 32'd0);
    end
    tick();
    chk("t1_res_e3", {31'd0, res_a}, 32'd1);
    chk("t1_rise_e3", {31'd0, rise_a}, 32'd1);
    chk("t1_fall_e3", {31'd0, fall_a}, 32'd0);
    tick();
    chk("t1_res_e4", {31'd0, res_a}, 32'd1);
    chk("t1_rise_e4", {31'd0, rise_a}, 32'd0);

    // T2: one-sample glitch, then a two-sample flip; neither may pass
    do_reset();
    in_a = 4'b1111;
    tick();
    in_a = 4'b0111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_res_g1", {31'd0, res_a}, 32'd0);
      chk("t2_pulse_g1", {30'd0, rise_a, fall_a}, 32'd0);
    end
    in_a = 4'b1111;
    repeat (2) tick();
    in_a = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t2_res_g2", {31'd0, res_a}, 32'd0);
      chk("t2_pulse_g2", {30'd0, rise_a, fall_a}, 32'd0);
    end
    // A flip of exactly three samples qualifies. It then falls back three
    // edges later.
    in_a = 4'b1111;
    repeat (3) tick();
    in_a = 4'b0000;
    tick();
    chk("t2_res_q3", {31'd0, res_a}, 32'd1);
    chk("t2_rise_q3", {31'd0, rise_a}, 32'd1);
    repeat (2) tick();
    chk("t2_res_hold", {31'd0, res_a}, 32'd1);
    tick();
    chk("t2_res_fall", {31'd0, res_a}, 32'd0);
    chk("t2_fall", {31'd0, fall_a}, 32'd1);

    // T3: the bubble on input 0
    do_reset();
    in_b = 4'b1110;
    #1;
    chk("t3_raw_1110", {31'd0, raw_b}, 32'd1);
    repeat (3) tick();
    chk("t3_res_e2", {31'd0, res_b}, 32'd0);
    tick();
    chk("t3_res_e3", {31'd0, res_b}, 32'd1);
    chk("t3_rise", {31'd0, rise_b}, 32'd1);
    in_b = 4'b1111;
    #1;
    chk("t3_raw_1111", {31'd0, raw_b}, 32'd0);
    repeat (3) tick();
    chk("t3_res_hold", {31'd0, res_b}, 32'd1);
    chk("t3_fall_early", {31'd0, fall_b}, 32'd0);
    tick();
    chk("t3_res_fall", {31'd0, res_b}, 32'd0);
    chk("t3_fall", {31'd0, fall_b}, 32'd1);
    tick();
    chk("t3_fall_end", {31'd0, fall_b}, 32'd0);

    // T4: enable is dropped after edge 2 and held low for two edges
    do_reset();
    in_a = 4'b1111;
    repeat (3) tick();
    chk("t4_res_e2", {31'd0, res_a}, 32'd0);
    en = 1'b0;
    repeat (2) tick();
    chk("t4_res_dis", {31'd0, res_a}, 32'd0);
    chk("t4_rise_dis", {31'd0, rise_a}, 32'd0);
    en = 1'b1;
    repeat (2) tick();
    chk("t4_res_re2", {31'd0, res_a}, 32'd0);
    tick();
    chk("t4_res_re3", {31'd0, res_a}, 32'd1);
    chk("t4_rise_re3", {31'd0, rise_a}, 32'd1);
    tick();

    // T5: an asynchronous reset pulse between edges, with the inputs still 1111
    chk("t5_res_pre", {31'd0, res_a}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_res_async", {31'd0, res_a}, 32'd0);
    chk("t5_pulse_async", {30'd0, rise_a, fall_a}, 32'd0);
    chk("t5_raw_in_rst", {31'd0, raw_a}, 32'd1);
    #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("t5_res_e2", {31'd0, res_a}, 32'd0);
    tick();
    chk("t5_res_e3", {31'd0, res_a}, 32'd1);
    chk("t5_rise_e3", {31'd0, rise_a}, 32'd1);

    // T6: FILTER_CYCLES = 1, inputs toggle every two cycles
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      in_c = (((k - 1) / 2) % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      chk($sformatf("t6_e%0d", k), {29'd0, res_c, rise_c, fall_c}, {29'd0, t6_exp[k]});
    end

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=0 expected=1");
    $fatal(1);
  end

endmodule
